// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped data cache.
// Fixed geometry: 8 blocks of 4 bytes each, 8-bit CPU byte address.
package dcache_pkg;
   localparam int TAG_W      = 3;
   localparam int INDEX_W    = 3;
   localparam int OFFSET_W   = 2;
   localparam int NUM_BLOCKS = 8;
   localparam int BLOCK_W    = 32;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      FETCH
   } state_t;
endpackage

// File: rtl/dcache_array.sv
// Cache storage: per-index valid/dirty/tag/data, combinational lookup and byte select.
// A block fill has priority over a byte write to the same index.
module dcache_array
   import dcache_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [INDEX_W-1:0]  index,
   input  logic [OFFSET_W-1:0] offset,
   input  logic [TAG_W-1:0]    tag,
   input  logic                byte_we,
   input  logic [7:0]          byte_wdata,
   input  logic                fill_we,
   input  logic [BLOCK_W-1:0]  fill_data,
   output logic                hit,
   output logic                line_valid,
   output logic                line_dirty,
   output logic [TAG_W-1:0]    line_tag,
   output logic [BLOCK_W-1:0]  line_data,
   output logic [7:0]          byte_rdata
);
   logic [NUM_BLOCKS-1:0] valid;
   logic [NUM_BLOCKS-1:0] dirty;
   logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
   logic [BLOCK_W-1:0]    data_mem [NUM_BLOCKS];

   assign line_valid = valid[index];
   assign line_dirty = dirty[index];
   assign line_tag   = tag_mem[index];
   assign line_data  = data_mem[index];
   assign hit        = valid[index] && (tag_mem[index] == tag);
   assign byte_rdata = data_mem[index][{offset, 3'b000} +: 8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         dirty <= '0;
      end else if (fill_we) begin
         valid[index] <= 1'b1;
         dirty[index] <= 1'b0;
      end else if (byte_we) begin
         dirty[index] <= 1'b1;
      end
   end

   // NOTE: tag/data have no reset; the valid bits alone qualify their contents,
   // so these stay plain RAM with no reset fan-out.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_mem[index]  <= tag;
         data_mem[index] <= fill_data;
      end else if (byte_we) begin
         data_mem[index][{offset, 3'b000} +: 8] <= byte_wdata;
      end
   end
endmodule

// File: rtl/dcache_controller.sv
// Write-back, write-allocate direct-mapped data cache controller.
// Misses write back a dirty victim (if any), fetch the block, then retry as a hit.
module dcache_controller
   import dcache_pkg::*;
(
   input  logic         CLK,
   input  logic         RESET,
   input  logic         READ,
   input  logic         WRITE,
   input  logic [7:0]   ADDRESS,
   input  logic [7:0]   WRITEDATA,
   output logic [7:0]   READDATA,
   output logic         BUSYWAIT,
   output logic         MEM_READ,
   output logic         MEM_WRITE,
   output logic [5:0]   MEM_ADDRESS,
   output logic [31:0]  MEM_WRITEDATA,
   input  logic [31:0]  MEM_READDATA,
   input  logic         MEM_BUSYWAIT
);
   state_t               state, next_state;
   logic [TAG_W-1:0]     addr_tag;
   logic [INDEX_W-1:0]   addr_index;
   logic [OFFSET_W-1:0]  addr_offset;
   logic                 hit, line_valid, line_dirty;
   logic [TAG_W-1:0]     line_tag;
   logic [BLOCK_W-1:0]   line_data;
   logic [7:0]           byte_rdata;
   logic                 byte_we, fill_we;

   assign addr_tag    = ADDRESS[7:5];
   assign addr_index  = ADDRESS[4:2];
   assign addr_offset = ADDRESS[1:0];

   dcache_array u_array (
      .clk        (CLK),
      .rst_n      (RESET),
      .index      (addr_index),
      .offset     (addr_offset),
      .tag        (addr_tag),
      .byte_we    (byte_we),
      .byte_wdata (WRITEDATA),
      .fill_we    (fill_we),
      .fill_data  (MEM_READDATA),
      .hit        (hit),
      .line_valid (line_valid),
      .line_dirty (line_dirty),
      .line_tag   (line_tag),
      .line_data  (line_data),
      .byte_rdata (byte_rdata)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state <= IDLE;
      else        state <= next_state;
   end

   // NOTE: every output gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state    = state;
      READDATA      = 8'h00;
      BUSYWAIT      = 1'b0;
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = ADDRESS[7:2];
      MEM_WRITEDATA = line_data;
      byte_we       = 1'b0;
      fill_we       = 1'b0;

      unique case (state)
         IDLE: begin
            if ((READ || WRITE) && !hit) begin
               BUSYWAIT   = 1'b1;
               next_state = (line_valid && line_dirty) ? WRITEBACK : FETCH;
            end else if (WRITE) begin
               byte_we = 1'b1;
            end else if (READ) begin
               READDATA = byte_rdata;
            end
         end
         WRITEBACK: begin
            BUSYWAIT    = 1'b1;
            MEM_WRITE   = 1'b1;
            MEM_ADDRESS = {line_tag, addr_index};
            if (!MEM_BUSYWAIT) next_state = FETCH;
         end
         FETCH: begin
            BUSYWAIT = 1'b1;
            MEM_READ = 1'b1;
            if (!MEM_BUSYWAIT) begin
               fill_we    = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase

      // Reset must silence the CPU stall and memory strobes in the same cycle,
      // even while a miss request is still being presented.
      if (!RESET) begin
         READDATA = 8'h00;
         BUSYWAIT = 1'b0;
         MEM_READ = 1'b0;
         MEM_WRITE = 1'b0;
         byte_we  = 1'b0;
         fill_we  = 1'b0;
      end
   end
endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: byte-level reference memory plus a
// readdata scoreboard, with a latency-programmable block memory model.
module tb_dcache_controller;
   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        READ = 1'b0;
   logic        WRITE = 1'b0;
   logic [7:0]  ADDRESS = 8'h00;
   logic [7:0]  WRITEDATA = 8'h00;
   logic [7:0]  READDATA;
   logic        BUSYWAIT;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA;
   logic [31:0] MEM_READDATA;
   logic        MEM_BUSYWAIT;

   int pass_cnt = 0;
   int check_cnt = 0;

   dcache_controller dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .READ          (READ),
      .WRITE         (WRITE),
      .ADDRESS       (ADDRESS),
      .WRITEDATA     (WRITEDATA),
      .READDATA      (READDATA),
      .BUSYWAIT      (BUSYWAIT),
      .MEM_READ      (MEM_READ),
      .MEM_WRITE     (MEM_WRITE),
      .MEM_ADDRESS   (MEM_ADDRESS),
      .MEM_WRITEDATA (MEM_WRITEDATA),
      .MEM_READDATA  (MEM_READDATA),
      .MEM_BUSYWAIT  (MEM_BUSYWAIT)
   );

   always #5 CLK = ~CLK;

   // Block memory model: each strobe stays busy for `lat` cycles, then completes.
   int          lat = 5;
   int          busy_cnt = 0;
   logic [31:0] mem [64];
   bit          written [64];

   function automatic logic [31:0] init_word(input logic [5:0] b);
      if (b == 6'h09) return 32'h4433_2211;
      return {b, 2'b11, ~b, 2'b00, b, 2'b01, ~b, 2'b10};
   endfunction

   function automatic logic [31:0] block_word(input logic [5:0] b);
      return written[b] ? mem[b] : init_word(b);
   endfunction

   assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (busy_cnt < lat);
   assign MEM_READDATA = block_word(MEM_ADDRESS);

   always @(posedge CLK) begin
      if (MEM_READ || MEM_WRITE) begin
         if (!MEM_BUSYWAIT) begin
            if (MEM_WRITE) begin
               mem[MEM_ADDRESS]     <= MEM_WRITEDATA;
               written[MEM_ADDRESS] <= 1'b1;
            end
            busy_cnt <= 0;
         end else begin
            busy_cnt <= busy_cnt + 1;
         end
      end else begin
         busy_cnt <= 0;
      end
   end

   // Architectural byte view and expected-readdata scoreboard.
   logic [7:0]  ref_mem [256];
   logic [7:0]  exp_q [$];

   // Observations from the most recent access.
   int          stall;
   bit          saw_wb, saw_fetch, overlap;
   logic [5:0]  wb_addr, fetch_addr;
   logic [31:0] wb_data;

   task automatic resync_ref();
      for (int a = 0; a < 256; a++) begin
         logic [7:0]  ad;
         logic [31:0] w;
         ad = 8'(a);
         w  = block_word(ad[7:2]);
         ref_mem[a] = w[{ad[1:0], 3'b000} +: 8];
      end
   endtask

   // Called at posedge+1; leaves at posedge+1 after the access is accepted.
   task automatic access(input string name, input logic rd, input logic wr,
                         input logic [7:0] addr, input logic [7:0] wdata);
      logic [7:0] exp_rd;
      bit         timed_out;
      READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
      exp_q.push_back((rd && !wr) ? ref_mem[addr] : 8'h00);
      if (wr) ref_mem[addr] = wdata;
      stall = 0; saw_wb = 0; saw_fetch = 0; overlap = 0; timed_out = 0;
      while (1) begin
         @(negedge CLK);
         if (MEM_READ && MEM_WRITE) overlap = 1;
         if (MEM_WRITE && !saw_wb) begin
            saw_wb = 1; wb_addr = MEM_ADDRESS; wb_data = MEM_WRITEDATA;
         end
         if (MEM_READ && !saw_fetch) begin
            saw_fetch = 1; fetch_addr = MEM_ADDRESS;
         end
         if (!BUSYWAIT) break;
         stall++;
         if (stall > 200) begin timed_out = 1; break; end
      end
      if (timed_out) begin
         check_cnt++;
         $display("FAIL %s timeout: BUSYWAIT still high after %0d cycles, required low", name, stall);
      end
      exp_rd = exp_q.pop_front();
      check_cnt++;
      if (READDATA !== exp_rd)
         $display("FAIL %s readdata: got %h expected %h", name, READDATA, exp_rd);
      else pass_cnt++;
      @(posedge CLK); #1;
      READ = 1'b0; WRITE = 1'b0;
   endtask

   task automatic apply_reset();
      RESET = 1'b0;
      @(negedge CLK); RESET = 1'b1;
      @(posedge CLK); #1;
      resync_ref();
   endtask

   task automatic test_reset();
      RESET = 1'b0; READ = 1'b1; ADDRESS = 8'h25;
      #3;
      check_cnt++;
      if (BUSYWAIT !== 1'b0) $display("FAIL reset busywait: got %b expected 0", BUSYWAIT);
      else pass_cnt++;
      check_cnt++;
      if (MEM_READ !== 1'b0) $display("FAIL reset mem_read: got %b expected 0", MEM_READ);
      else pass_cnt++;
      check_cnt++;
      if (MEM_WRITE !== 1'b0) $display("FAIL reset mem_write: got %b expected 0", MEM_WRITE);
      else pass_cnt++;
      check_cnt++;
      if (READDATA !== 8'h00) $display("FAIL reset readdata: got %h expected 00", READDATA);
      else pass_cnt++;
      READ = 1'b0;
      apply_reset();
   endtask

   task automatic test_cold_read();
      lat = 5;
      access("cold_read", 1'b1, 1'b0, 8'h25, 8'h00);
      check_cnt++;
      if (stall !== 7) $display("FAIL cold_read stall: got %0d expected 7", stall);
      else pass_cnt++;
      check_cnt++;
      if (saw_wb || !saw_fetch || fetch_addr !== 6'h09)
         $display("FAIL cold_read strobes: got wb=%b fetch=%b addr=%h expected wb=0 fetch=1 addr=09",
                  saw_wb, saw_fetch, fetch_addr);
      else pass_cnt++;
   endtask

   task automatic test_write_hit();
      @(negedge CLK);
      check_cnt++;
      if (BUSYWAIT !== 1'b0) $display("FAIL idle busywait: got %b expected 0", BUSYWAIT);
      else pass_cnt++;
      @(posedge CLK); #1;
      access("write_hit", 1'b0, 1'b1, 8'h25, 8'hAB);
      check_cnt++;
      if (stall !== 0 || saw_wb || saw_fetch)
         $display("FAIL write_hit stall: got stall=%0d wb=%b fetch=%b expected 0/0/0", stall, saw_wb, saw_fetch);
      else pass_cnt++;
      access("write_hit_readback", 1'b1, 1'b0, 8'h25, 8'h00);
      check_cnt++;
      if (stall !== 0) $display("FAIL write_hit_readback stall: got %0d expected 0", stall);
      else pass_cnt++;
   endtask

   task automatic test_dirty_eviction();
      access("dirty_evict", 1'b1, 1'b0, 8'hA5, 8'h00);
      check_cnt++;
      if (!saw_wb || wb_addr !== 6'h09 || wb_data !== 32'h4433_AB11)
         $display("FAIL dirty_evict writeback: got wb=%b addr=%h data=%h expected 1/09/4433ab11",
                  saw_wb, wb_addr, wb_data);
      else pass_cnt++;
      check_cnt++;
      if (!saw_fetch || fetch_addr !== 6'h29)
         $display("FAIL dirty_evict fetch: got fetch=%b addr=%h expected 1/29", saw_fetch, fetch_addr);
      else pass_cnt++;
      check_cnt++;
      if (overlap !== 1'b0) $display("FAIL dirty_evict overlap: got %b expected 0", overlap);
      else pass_cnt++;
      check_cnt++;
      if (stall !== 13) $display("FAIL dirty_evict stall: got %0d expected 13", stall);
      else pass_cnt++;
   endtask

   task automatic test_clean_eviction();
      access("clean_evict", 1'b1, 1'b0, 8'h25, 8'h00);
      check_cnt++;
      if (saw_wb || !saw_fetch || fetch_addr !== 6'h09 || stall !== 7)
         $display("FAIL clean_evict: got wb=%b fetch=%b addr=%h stall=%0d expected 0/1/09/7",
                  saw_wb, saw_fetch, fetch_addr, stall);
      else pass_cnt++;
   endtask

   task automatic test_both_high();
      logic [31:0] exp_wb;
      access("both_high", 1'b1, 1'b1, 8'h24, 8'h5A);
      check_cnt++;
      if (stall !== 0) $display("FAIL both_high stall: got %0d expected 0", stall);
      else pass_cnt++;
      exp_wb = {ref_mem[8'h27], ref_mem[8'h26], ref_mem[8'h25], ref_mem[8'h24]};
      access("both_high_evict", 1'b1, 1'b0, 8'hA4, 8'h00);
      check_cnt++;
      if (!saw_wb || wb_data !== exp_wb)
         $display("FAIL both_high_evict writeback: got wb=%b data=%h expected 1/%h", saw_wb, wb_data, exp_wb);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_fetch();
      int n_fetch;
      lat = 5;
      access("mid_fetch_fill", 1'b1, 1'b0, 8'h41, 8'h00);
      READ = 1'b1; ADDRESS = 8'h01;
      n_fetch = 0;
      for (int i = 0; i < 20 && n_fetch < 3; i++) begin
         @(negedge CLK);
         if (MEM_READ) n_fetch++;
      end
      check_cnt++;
      if (n_fetch !== 3) $display("FAIL mid_fetch reach: got %0d fetch cycles expected 3", n_fetch);
      else pass_cnt++;
      RESET = 1'b0;
      #1;
      check_cnt++;
      if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0)
         $display("FAIL mid_fetch abort: got mem_read=%b busywait=%b expected 0/0", MEM_READ, BUSYWAIT);
      else pass_cnt++;
      READ = 1'b0;
      @(negedge CLK); RESET = 1'b1;
      @(posedge CLK); #1;
      resync_ref();
      access("mid_fetch_retry", 1'b1, 1'b0, 8'h01, 8'h00);
      check_cnt++;
      if (!saw_fetch || stall !== 7)
         $display("FAIL mid_fetch_retry miss: got fetch=%b stall=%0d expected 1/7", saw_fetch, stall);
      else pass_cnt++;
   endtask

   task automatic test_request_drop();
      int cyc;
      lat = 3;
      READ = 1'b1; ADDRESS = 8'h6C;
      cyc = 0;
      while (!MEM_READ && cyc < 50) begin @(negedge CLK); cyc++; end
      READ = 1'b0;
      while (MEM_READ && cyc < 50) begin @(negedge CLK); cyc++; end
      check_cnt++;
      if (cyc >= 50) $display("FAIL drop completion: got %0d cycles expected fetch to finish", cyc);
      else pass_cnt++;
      @(posedge CLK); #1;
      access("drop_retry", 1'b1, 1'b0, 8'h6C, 8'h00);
      check_cnt++;
      if (stall !== 0) $display("FAIL drop_retry stall: got %0d expected 0", stall);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      bit any_overlap;
      any_overlap = 0;
      for (int n = 0; n < 40; n++) begin
         logic [2:0] t, i;
         logic [1:0] o;
         logic       wr;
         t  = 3'($urandom_range(0, 7));
         i  = 3'($urandom_range(0, 1));
         o  = 2'($urandom_range(0, 3));
         wr = 1'($urandom_range(0, 1));
         lat = $urandom_range(0, 3);
         access("back_to_back", !wr, wr, {t, i, o}, 8'($urandom));
         if (overlap) any_overlap = 1;
      end
      check_cnt++;
      if (any_overlap) $display("FAIL back_to_back overlap: got 1 expected 0");
      else pass_cnt++;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resync_ref();
      test_reset();
      test_cold_read();
      test_write_hit();
      test_dirty_eviction();
      test_clean_eviction();
      test_both_high();
      test_reset_mid_fetch();
      test_request_drop();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end
endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed: 8 blocks, 4 bytes per block, 8-bit CPU address.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset (RESET=0 resets).
REQ-004 READ  input  1  CPU load request, held until BUSYWAIT low.
REQ-005 WRITE  input  1  CPU store request, held until BUSYWAIT low.
REQ-006 ADDRESS  input  8  CPU byte address: tag[7:5], index[4:2], offset[1:0].
REQ-007 WRITEDATA  input  8  CPU store byte.
REQ-008 READDATA  output  8  CPU load byte.
REQ-009 BUSYWAIT  output  1  stall to CPU; the PC holds while high.
REQ-010 MEM_READ  output  1  block fetch strobe to data memory.
REQ-011 MEM_WRITE  output  1  block write-back strobe to data memory.
REQ-012 MEM_ADDRESS  output  6  memory block address {tag,index}.
REQ-013 MEM_WRITEDATA  output  32  write-back block, byte 0 in [7:0].
REQ-014 MEM_READDATA  input  32  fetched block, byte 0 in [7:0].
REQ-015 MEM_BUSYWAIT  input  1  memory busy; low means the current strobe completes this cycle.

Function
REQ-016 Storage SHALL be direct-mapped: per index, valid bit, dirty bit, 3-bit tag, and 32-bit data.
REQ-017 hit = valid[index] & (tag[index]==ADDRESS[7:5]); the hit check SHALL be combinational.
REQ-018 FSM states SHALL be IDLE, WRITEBACK, FETCH.
REQ-019 IDLE, read hit: READDATA = selected byte combinationally; BUSYWAIT=0 in the same cycle.
REQ-020 IDLE, write hit: the byte is written at the next edge and dirty set to 1; BUSYWAIT=0.
REQ-021 IDLE, miss (READ|WRITE, !hit): BUSYWAIT=1 combinationally; next state WRITEBACK if valid&dirty, else FETCH.
REQ-022 WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=stored block; stay while MEM_BUSYWAIT=1; on an edge with MEM_BUSYWAIT=0, go to FETCH.
REQ-023 FETCH: MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2]; on an edge with MEM_BUSYWAIT=0, load MEM_READDATA, set valid=1, dirty=0 and tag=ADDRESS[7:5], then go to IDLE.
REQ-024 After FETCH the retried access SHALL hit in IDLE: a miss costs fill latency plus 1 cycle.
REQ-025 BUSYWAIT SHALL be 1 in WRITEBACK and FETCH regardless of READ/WRITE.
REQ-026 Only one of MEM_READ and MEM_WRITE SHALL be high at a time; both are 0 in IDLE.
REQ-027 If READ and WRITE are both high, the access SHALL be treated as WRITE.
REQ-028 If a request drops mid-miss, the write-back/fetch SHALL complete anyway; no other state changes.
REQ-029 No request SHALL mean no array update and BUSYWAIT=0.
REQ-030 READDATA SHALL be 0 when no read hit is in progress.

Reset
REQ-031 RESET=0 SHALL immediately force state=IDLE and clear all valid and dirty bits.
REQ-032 RESET=0 SHALL immediately force BUSYWAIT=0, MEM_READ=0 and MEM_WRITE=0.
REQ-033 Tag and data contents are don't-care after reset.
REQ-034 Reset during WRITEBACK or FETCH SHALL abort the transfer; no partial fill is recorded.

Structure
REQ-035 A shared package dcache_pkg SHALL hold the state enum and constants TAG_W=3, INDEX_W=3, OFFSET_W=2 and NUM_BLOCKS=8.
REQ-036 Storage (valid/dirty/tag/data, byte select, byte write) SHALL be one sub-module, dcache_array; the FSM and memory strobes stay in dcache_controller.

Verification
REQ-037 Cold read: reset, then READ ADDRESS=0x25 with memory returning block 0x44332211 after 5 busy cycles -> FETCH with MEM_ADDRESS=0x09, BUSYWAIT high for 7 cycles, then READDATA=0x22.
REQ-038 Write hit: after REQ-037, WRITE 0x25 data 0xAB -> BUSYWAIT stays 0, no memory strobe; a later READ 0x25 returns 0xAB.
REQ-039 Dirty eviction: after REQ-038, READ 0xA5 -> WRITEBACK MEM_ADDRESS=0x09 with MEM_WRITEDATA=0x4433AB11, then FETCH MEM_ADDRESS=0x29, MEM_READ never overlapping MEM_WRITE.
REQ-040 Clean eviction: a fill followed by a conflicting read at the same index -> no WRITEBACK, FETCH only.
REQ-041 Reset mid-FETCH: assert RESET=0 during cycle 3 of a fetch -> MEM_READ and BUSYWAIT drop immediately; the next READ of the same address misses.
REQ-042 READ and WRITE both high on a hit -> write performed, dirty set, READDATA=0.
